// File: rtl/fir_pkg.sv
// Shared constants and FSM state encoding for the FIR tap sequencer.
package fir_pkg;
  localparam int unsigned NUM_TAPS = 64;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 6;
  localparam logic [3:0]  OP_MUL   = 4'h2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_WRITE,
    ST_RUN,
    ST_DRAIN,
    ST_OUT
  } state_e;
endpackage

// File: rtl/fir_acc.sv
// Tap accumulator with synchronous clear; FIR_SAT_EN selects saturating
// signed addition instead of modulo-2^DATA_W wrap.
module fir_acc #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              add_en,
  input  logic [DATA_W-1:0] operand,
  output logic [DATA_W-1:0] acc
);
  logic [DATA_W-1:0] sum_c;

  always_comb begin
    sum_c = acc + operand;
`ifdef FIR_SAT_EN
    // Same-sign operands producing a flipped sign mean signed overflow.
    if ((acc[DATA_W-1] == operand[DATA_W-1]) && (sum_c[DATA_W-1] != acc[DATA_W-1]))
      sum_c = acc[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk) begin
    if (reset)       acc <= '0;
    else if (clear)  acc <= '0;
    else if (add_en) acc <= sum_c;
  end
endmodule

// File: rtl/fir_tap_sequencer.sv
// Sequences one FIR output per accepted sample: history write, NUM_TAPS
// multiply issues, 2-cycle drain, output handshake. FIR_SAT_EN: saturating acc.
module fir_tap_sequencer #(
  parameter int unsigned NUM_TAPS = fir_pkg::NUM_TAPS,
  parameter int unsigned DATA_W   = fir_pkg::DATA_W,
  parameter int unsigned ADDR_W   = fir_pkg::ADDR_W,
  parameter logic [3:0]  OP_MUL   = fir_pkg::OP_MUL
) (
  input  logic              rclk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic [ADDR_W-1:0] coef_addr,
  output logic              coef_cen,
  output logic              coef_wen,
  output logic [ADDR_W-1:0] hist_addr,
  output logic              hist_cen,
  output logic              hist_wen,
  output logic [DATA_W-1:0] hist_d,
  output logic              alu_en,
  output logic [3:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  output logic              y_valid,
  input  logic              y_ready,
  output logic [DATA_W-1:0] y_data,
  output logic              busy
);
  import fir_pkg::*;

  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(NUM_TAPS - 1);

  state_e            state, state_n;
  logic [ADDR_W-1:0] k, k_n;
  logic [ADDR_W-1:0] wptr, wptr_n;
  logic [DATA_W-1:0] sample, sample_n;
  logic              init_pending, init_pending_n;
  logic              issue_d1, issue_d2;
  logic              acc_clear_c;

  logic              s_ready_n, coef_cen_n, hist_cen_n, hist_wen_n;
  logic              alu_en_n, y_valid_n, busy_n;
  logic [ADDR_W-1:0] coef_addr_n, hist_addr_n;
  logic [DATA_W-1:0] hist_d_n;
  logic [3:0]        alu_opcode_n;

  assign coef_wen    = 1'b1;
  assign acc_clear_c = (state == ST_WRITE);

  // State, counters and registered outputs (outputs track the next state).
  always_ff @(posedge rclk) begin
    if (reset) begin
      state        <= ST_IDLE;
      k            <= '0;
      wptr         <= '0;
      sample       <= '0;
      init_pending <= 1'b1;
      issue_d1     <= 1'b0;
      issue_d2     <= 1'b0;
      s_ready      <= 1'b0;
      coef_addr    <= '0;
      coef_cen     <= 1'b1;
      hist_addr    <= '0;
      hist_cen     <= 1'b1;
      hist_wen     <= 1'b1;
      hist_d       <= '0;
      alu_en       <= 1'b0;
      alu_opcode   <= '0;
      y_valid      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      k            <= k_n;
      wptr         <= wptr_n;
      sample       <= sample_n;
      init_pending <= init_pending_n;
      issue_d1     <= (state == ST_RUN);
      issue_d2     <= issue_d1;
      s_ready      <= s_ready_n;
      coef_addr    <= coef_addr_n;
      coef_cen     <= coef_cen_n;
      hist_addr    <= hist_addr_n;
      hist_cen     <= hist_cen_n;
      hist_wen     <= hist_wen_n;
      hist_d       <= hist_d_n;
      alu_en       <= alu_en_n;
      alu_opcode   <= alu_opcode_n;
      y_valid      <= y_valid_n;
      busy         <= busy_n;
    end
  end

  // Next-state, tap counter and write-pointer logic.
  always_comb begin
    state_n        = state;
    k_n            = k;
    wptr_n         = wptr;
    sample_n       = sample;
    init_pending_n = init_pending;
    case (state)
      ST_IDLE: begin
        if (init_pending) begin
          state_n        = ST_INIT;
          init_pending_n = 1'b0;
          k_n            = '0;
        end else if (s_valid) begin
          sample_n = s_data;
          state_n  = ST_WRITE;
        end
      end
      ST_INIT: begin
        k_n = k + ADDR_W'(1);
        if (k == K_LAST) begin
          state_n = ST_IDLE;
          k_n     = '0;
        end
      end
      ST_WRITE: begin
        k_n     = '0;
        state_n = ST_RUN;
      end
      ST_RUN: begin
        k_n = k + ADDR_W'(1);
        if (k == K_LAST) begin
          state_n = ST_DRAIN;
          k_n     = '0;
        end
      end
      ST_DRAIN: begin
        k_n = k + ADDR_W'(1);
        if (k == ADDR_W'(1)) begin
          state_n = ST_OUT;
          k_n     = '0;
          wptr_n  = wptr + ADDR_W'(1);
        end
      end
      ST_OUT: begin
        if (y_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Output values for the upcoming state; the init sweep zeroes history.
  always_comb begin
    s_ready_n    = 1'b0;
    coef_addr_n  = '0;
    coef_cen_n   = 1'b1;
    hist_addr_n  = '0;
    hist_cen_n   = 1'b1;
    hist_wen_n   = 1'b1;
    hist_d_n     = '0;
    alu_en_n     = 1'b0;
    alu_opcode_n = '0;
    y_valid_n    = 1'b0;
    busy_n       = 1'b1;
    case (state_n)
      ST_IDLE: begin
        s_ready_n = 1'b1;
        busy_n    = 1'b0;
      end
      ST_INIT: begin
        hist_cen_n  = 1'b0;
        hist_wen_n  = 1'b0;
        hist_addr_n = k_n;
      end
      ST_WRITE: begin
        hist_cen_n  = 1'b0;
        hist_wen_n  = 1'b0;
        hist_addr_n = wptr_n;
        hist_d_n    = sample_n;
      end
      ST_RUN: begin
        coef_cen_n   = 1'b0;
        hist_cen_n   = 1'b0;
        coef_addr_n  = k_n;
        hist_addr_n  = wptr_n - k_n;
        alu_en_n     = 1'b1;
        alu_opcode_n = OP_MUL;
      end
      ST_OUT:  y_valid_n = 1'b1;
      default: ;
    endcase
  end

  // Products return two cycles after issue (RAM read + ALU register).
  fir_acc #(.DATA_W(DATA_W)) u_acc (
    .clk     (rclk),
    .reset   (reset),
    .clear   (acc_clear_c),
    .add_en  (issue_d2),
    .operand (alu_result),
    .acc     (y_data)
  );
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench: coefficient/history RAMs and a registered ALU around the
// sequencer; expected outputs from hand values and a small history model.
module tb_fir_tap_sequencer;
  logic        rclk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic [5:0]  coef_addr;
  logic        coef_cen, coef_wen;
  logic [5:0]  hist_addr;
  logic        hist_cen, hist_wen;
  logic [15:0] hist_d;
  logic        alu_en;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_result = '0;
  logic        y_valid;
  logic        y_ready = 1'b0;
  logic [15:0] y_data;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t_acc = 0;
  int mw = 0;
  int mk = 0;
  logic [5:0]  wr_addr = '0;
  logic [15:0] cmem [64];
  logic [15:0] hmem [64];
  logic [15:0] hm   [64];
  logic [15:0] coef_q = '0;
  logic [15:0] hist_q = '0;

  fir_tap_sequencer dut (
    .rclk(rclk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .coef_addr(coef_addr), .coef_cen(coef_cen), .coef_wen(coef_wen),
    .hist_addr(hist_addr), .hist_cen(hist_cen), .hist_wen(hist_wen), .hist_d(hist_d),
    .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_result(alu_result),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .busy(busy)
  );

  always #5 rclk = ~rclk;
  always @(posedge rclk) cyc++;

  // Synchronous-read RAMs and a one-stage multiplier.
  always @(posedge rclk) begin
    if (!coef_cen) coef_q <= cmem[coef_addr];
    if (!hist_cen) begin
      if (!hist_wen) hmem[hist_addr] <= hist_d;
      else           hist_q <= hmem[hist_addr];
    end
    alu_result <= 16'(coef_q * hist_q);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Every issue cycle must address coef[k] and history[wptr-k].
  always @(negedge rclk) begin
    if (alu_en) begin
      check("run_addr", {alu_opcode, coef_addr, hist_addr}, {4'h2, 6'(mk), 6'(mw - mk)});
      mk++;
    end else begin
      mk = 0;
    end
  end

  function automatic logic [15:0] acc_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] s;
    s = a + b;
`ifdef FIR_SAT_EN
    if (a[15] == b[15] && s[15] != a[15]) s = a[15] ? 16'h8000 : 16'h7FFF;
`endif
    return s;
  endfunction

  function automatic logic [15:0] model_y();
    logic [15:0] acc;
    acc = '0;
    for (int k = 0; k < 64; k++) acc = acc_add(acc, 16'(cmem[k] * hm[6'(mw - k)]));
    return acc;
  endfunction

  task automatic check_rst(input string tag);
    check(tag, {y_valid, s_ready, alu_en, coef_cen, coef_wen, hist_cen, hist_wen, busy, y_data},
               {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0});
  endtask

  task automatic check_sweep(input string tag);
    bit bad = 1'b0;
    bit ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge rclk);
      if (!busy || s_ready || y_valid || hist_wen || hist_d != 16'h0) bad = 1'b1;
    end
    check({tag, "_sweep"}, 32'(bad), 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge rclk);
      if (s_ready) begin ok = 1'b1; break; end
    end
    check({tag, "_idle"}, 32'(ok), 1);
  endtask

  task automatic offer(input logic [15:0] v);
    @(negedge rclk);
    s_valid = 1'b1;
    s_data  = v;
  endtask

  task automatic take();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (s_ready) begin ok = 1'b1; break; end
      @(negedge rclk);
    end
    check("accept", 32'(ok), 1);
    if (ok) begin
      @(posedge rclk); #1;
      s_valid = 1'b0;
      t_acc   = cyc;
      hm[6'(mw)] = s_data;
      @(negedge rclk);
      wr_addr = hist_addr;
      check("write", {hist_cen, hist_wen, hist_addr, hist_d}, {2'b00, 6'(mw), s_data});
    end else begin
      s_valid = 1'b0;
    end
  endtask

  task automatic wait_out(input string tag, input logic [15:0] exp);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge rclk);
      if (y_valid) begin ok = 1'b1; break; end
    end
    check({tag, "_valid"}, 32'(ok), 1);
    check({tag, "_lat"}, 32'(cyc - t_acc), 67);
    check(tag, y_data, exp);
  endtask

  task automatic retire();
    y_ready = 1'b1;
    @(posedge rclk); #1;
    y_ready = 1'b0;
    mw++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp;
    bit ok;
    for (int k = 0; k < 64; k++) begin
      cmem[k] = 16'(k);
      hm[k]   = '0;
    end
    reset = 1'b1;
    repeat (3) @(negedge rclk);
    check_rst("rst_state");
    reset = 1'b0;
    check_sweep("init");

    // Impulse through a ramp of coefficients reproduces the ramp.
    for (int n = 0; n < 64; n++) begin
      offer(n == 0 ? 16'd1 : 16'd0);
      take();
      wait_out("impulse", 16'(n));
      retire();
    end

    // Constant input into unity taps settles at 64*2.
    for (int k = 0; k < 64; k++) cmem[k] = 16'd1;
    for (int n = 0; n < 64; n++) begin
      offer(16'd2);
      take();
      wait_out("const", model_y());
      if (n == 63) check("const_128", y_data, 16'd128);
      retire();
    end

    // Output held under backpressure while the next sample waits.
    offer(16'd3);
    take();
    exp = model_y();
    wait_out("bp_first", exp);
    offer(16'd4);
    repeat (20) begin
      @(negedge rclk);
      check("bp_hold", {y_valid, s_ready, y_data}, {1'b1, 1'b0, exp});
    end
    retire();
    check("bp_retire", {y_valid, s_ready, busy}, 3'b010);
    take();
    wait_out("bp_second", model_y());
    retire();

    // 130 samples in: the write pointer has wrapped to 2.
    offer(16'd5);
    take();
    check("wrap_wptr", wr_addr, 6'd2);
    wait_out("wrap", model_y());
    retire();

    // Abort mid-run, then a fresh-start result.
    offer(16'd7);
    take();
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge rclk);
      if (alu_en && coef_addr == 6'd30) begin ok = 1'b1; break; end
    end
    check("abort_reach", 32'(ok), 1);
    reset = 1'b1;
    @(posedge rclk); #1;
    check_rst("abort_rst");
    @(negedge rclk);
    reset = 1'b0;
    for (int k = 0; k < 64; k++) hm[k] = '0;
    mw = 0;
    check_sweep("abort");
    offer(16'd9);
    take();
    wait_out("fresh", 16'd9);
    check("fresh_model", y_data, model_y());
    retire();

    // 0x7FFF*1 + 0x7FFF*9 (low half 0x7FF7) overflows 16-bit signed.
    for (int k = 0; k < 64; k++) cmem[k] = 16'h7FFF;
    offer(16'd1);
    take();
`ifdef FIR_SAT_EN
    wait_out("ovf", 16'h7FFF);
`else
    wait_out("ovf", 16'hFFF6);
`endif
    check("ovf_model", y_data, model_y());
    retire();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
